// File: rtl/matmult_pkg.sv
// Shared sizing helpers, state encoding and defaults for the matrix multiplier
// result path.
package matmult_pkg;

  localparam int unsigned DSIZE_DEFAULT = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int unsigned nelem(input int unsigned rows, input int unsigned cols);
    return rows * cols;
  endfunction

  // Index width never drops to zero, so a 1x1 matrix still gets a legal 1-bit index.
  function automatic int unsigned idxw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned ptrw(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int unsigned cntw(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/matrix_slot_fifo.sv
// Whole-matrix slot buffer: depth slots, explicit pointer wrap so any depth
// works; push is accepted when full if a pop happens in the same cycle.
module matrix_slot_fifo
  import matmult_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [cntw(DEPTH)-1:0]     count
);

  localparam int unsigned PW = ptrw(DEPTH);
  localparam int unsigned CW = cntw(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= nxt(tail);
      if (do_pop)  head <= nxt(head);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures full product matrices into a slot buffer and streams them out one
// element per valid/ready transfer in row-major order.
module matrix_result_serializer
  import matmult_pkg::*;
#(
  parameter int unsigned dsize = DSIZE_DEFAULT,
  parameter int unsigned rowsA = 10,
  parameter int unsigned colsB = 10,
  parameter int unsigned depth = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vin,
  input  logic [rowsA*colsB*dsize-1:0]   C,
  output logic [dsize-1:0]               dout,
  output logic                           dvalid,
  input  logic                           dready,
  output logic                           dfirst,
  output logic                           dlast,
  output logic                           busy,
  output logic                           overflow
);

  localparam int unsigned NELEM = nelem(rowsA, colsB);
  localparam int unsigned IW    = idxw(NELEM);
  localparam int unsigned CW    = cntw(depth);
  localparam int unsigned MW    = NELEM * dsize;

  state_t        state;
  logic [IW-1:0] e;
  logic [MW-1:0] slot;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          xfer;
  logic          at_last;
  logic          pop;
  logic          accept;

  assign dvalid  = (state == STREAM);
  assign xfer    = dvalid && dready;
  assign at_last = (e == IW'(NELEM - 1));
  assign pop     = xfer && at_last;
  assign accept  = vin && (!full || pop);
  assign dfirst  = dvalid && (e == '0);
  assign dlast   = dvalid && at_last;
  assign busy    = !empty;

  matrix_slot_fifo #(
    .W     (MW),
    .DEPTH (depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vin),
    .pop   (pop),
    .wdata (C),
    .rdata (slot),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      e        <= '0;
      overflow <= 1'b0;
    end else begin
      if (vin && full && !pop) overflow <= 1'b1;
      if (xfer) e <= at_last ? '0 : e + 1'b1;
      case (state)
        IDLE:    if (vin) state <= STREAM;
        // Leave only when the last buffered matrix pops with nothing arriving.
        STREAM:  if (pop && count == CW'(1) && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Head-slot element mux, forced to zero while nothing is presented.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < NELEM; i++) begin
      if (dvalid && e == IW'(i)) dout = slot[i*dsize +: dsize];
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Bench for matrix_result_serializer (2x2, 8-bit, depth 2): queue-based model
// compared every cycle, plus directed literal pins and random traffic.
module tb_matrix_result_serializer;

  localparam int unsigned DS = 8;
  localparam int unsigned RA = 2;
  localparam int unsigned CB = 2;
  localparam int unsigned DP = 2;
  localparam int unsigned NE = RA * CB;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        vin    = 1'b0;
  logic        dready = 1'b0;
  logic [31:0] C      = '0;
  logic [7:0]  dout;
  logic        dvalid, dfirst, dlast, busy, overflow;

  matrix_result_serializer #(
    .dsize (DS),
    .rowsA (RA),
    .colsB (CB),
    .depth (DP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vin      (vin),
    .C        (C),
    .dout     (dout),
    .dvalid   (dvalid),
    .dready   (dready),
    .dfirst   (dfirst),
    .dlast    (dlast),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  logic [31:0] mq[$];
  int unsigned me   = 0;
  bit          movf = 1'b0;
  logic [7:0]  xlog[$];
  int          total  = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic v, input logic [31:0] c, input logic r);
    bit full;
    bit pop;
    if (!rst) begin
      mq.delete();
      me   = 0;
      movf = 1'b0;
      return;
    end
    full = (mq.size() == DP);
    pop  = 1'b0;
    if (mq.size() != 0 && r) begin
      if (me == NE - 1) begin
        me  = 0;
        pop = 1'b1;
        void'(mq.pop_front());
      end else begin
        me++;
      end
    end
    if (v) begin
      if (!full || pop) mq.push_back(c);
      else movf = 1'b1;
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] c, input logic r);
    @(negedge clk);
    vin    = v;
    C      = c;
    dready = r;
    if (dvalid && dready) xlog.push_back(dout);
    @(posedge clk);
    model_edge(v, c, r);
  endtask

  task automatic chk_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, xlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < xlog.size(); i++)
      chk($sformatf("%s[%0d]", name, i), xlog[i], exp[i]);
  endtask

  always @(posedge clk) begin
    logic [31:0] h;
    logic [7:0]  ed;
    #1;
    h  = (mq.size() != 0) ? mq[0] : 32'h0;
    ed = (mq.size() != 0) ? h[me*8 +: 8] : 8'h00;
    chk("dvalid",   dvalid,   mq.size() != 0);
    chk("dout",     dout,     ed);
    chk("dfirst",   dfirst,   mq.size() != 0 && me == 0);
    chk("dlast",    dlast,    mq.size() != 0 && me == NE - 1);
    chk("busy",     busy,     mq.size() != 0);
    chk("overflow", overflow, movf);
  end

  initial begin
    logic [7:0] exp[$];

    // Power-on reset
    cyc(1'b0, 32'h0, 1'b0);
    #1;
    chk("rst_dvalid", dvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    cyc(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;

    // Basic single matrix
    xlog.delete();
    cyc(1'b1, 32'h04030201, 1'b1);
    #1;
    chk("lat_dout", dout, 8'h01);
    chk("lat_first", dfirst, 1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    #1;
    chk("basic_last_dout", dout, 8'h04);
    chk("basic_dlast", dlast, 1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1);
    #1;
    chk("basic_busy_end", busy, 0);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_log("basic", exp);

    // Back-pressure
    xlog.delete();
    cyc(1'b1, 32'h04030201, 1'b1);
    foreach (exp[i]) ;
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk_log("bp", exp);

    // Back-to-back
    xlog.delete();
    cyc(1'b1, 32'h04030201, 1'b1);
    cyc(1'b1, 32'h08070605, 1'b1);
    repeat (9) cyc(1'b0, 32'h0, 1'b1);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    chk_log("b2b", exp);

    // Overflow
    xlog.delete();
    cyc(1'b1, 32'hA1A1A1A1, 1'b0);
    cyc(1'b1, 32'hB2B2B2B2, 1'b0);
    #1 chk("ovf_before", overflow, 0);
    cyc(1'b1, 32'hC3C3C3C3, 1'b0);
    #1 chk("ovf_after", overflow, 1);
    repeat (10) cyc(1'b0, 32'h0, 1'b1);
    exp = '{8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hB2};
    chk_log("ovf_drain", exp);
    #1 chk("ovf_sticky", overflow, 1);

    // Reset mid-stream
    cyc(1'b1, 32'h04030201, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_dvalid", dvalid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_dfirst", dfirst, 0);
    mq.delete();
    me   = 0;
    movf = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    cyc(1'b1, 32'h44332211, 1'b1);
    #1;
    chk("mrst_fresh_dout", dout, 8'h11);
    chk("mrst_fresh_first", dfirst, 1);
    repeat (5) cyc(1'b0, 32'h0, 1'b1);

    // Full with same-cycle final pop and capture
    xlog.delete();
    cyc(1'b1, 32'h04030201, 1'b0);
    cyc(1'b1, 32'h08070605, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h0C0B0A09, 1'b1);
    #1;
    chk("fp_ovf", overflow, 0);
    chk("fp_busy", busy, 1);
    chk("fp_dout", dout, 8'h05);
    repeat (10) cyc(1'b0, 32'h0, 1'b1);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C};
    chk_log("fullpop", exp);

    // Random traffic
    repeat (600) cyc($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) == 1);
    repeat (30) cyc(1'b0, 32'h0, 1'b1);
    #1 chk("rand_drained", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Downstream stage of the matrix multiplier: captures the flat row-major product bus C on each result-valid pulse.
- Buffers up to depth complete matrices and streams them out one element per transfer over a valid/ready interface.
- Decouples the multiplier, which can emit a result every cycle, from narrow consumers such as memory writers and UART/AXI-stream bridges.

Parameters:
- dsize, 8, element width in bits (matches multiplier).
- rowsA, 10, rows of result matrix.
- colsB, 10, columns of result matrix.
- depth, 2, number of whole matrices buffered (>=1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- vin  input  1  result valid, driven by multiplier vout; single- or multi-cycle pulses, each high cycle is one matrix.
- C  input  rowsA*colsB*dsize  result matrix; element (m,n) at bits ((m*colsB+n)+1)*dsize-1 -: dsize.
- dout  output  dsize  current element.
- dvalid  output  1  dout valid.
- dready  input  1  consumer ready.
- dfirst  output  1  dout is element (0,0) of a matrix.
- dlast  output  1  dout is element (rowsA-1,colsB-1).
- busy  output  1  buffer non-empty.
- overflow  output  1  sticky, a vin was dropped.

Behaviour:
- Reset (rst=0, async): buffer empty, read/write pointers 0, element index 0, overflow 0. Outputs dvalid=0, dfirst=0, dlast=0, busy=0, dout=0.
- Capture: every rising edge with vin=1 writes C into the write slot and advances the write pointer (mod depth), but only if the buffer is not full or a pop occurs in the same cycle.
- Drop: vin=1 while full with no same-cycle pop drops the matrix and sets overflow=1. overflow stays 1 until reset.
- Latency: C captured at edge N appears as element 0 on dout, with dvalid=1, in the cycle after edge N if the buffer was empty.
- Element order is row-major: index e=0..rowsA*colsB-1, dout = slot[head][(e+1)*dsize-1 -: dsize].
- dout is a mux from storage, not an extra register stage.
- Transfer occurs when dvalid&&dready at a rising edge; e increments on each transfer.
- On the transfer with e = last: e returns to 0, the head slot is popped and the read pointer advances (mod depth). The next matrix, if present, is presented in the very next cycle (no bubble).
- dvalid=1 iff the buffer is non-empty, independent of dready (dready must not gate dvalid).
- dout, dfirst and dlast are held stable while dvalid=1 and dready=0.
- dfirst = dvalid && e==0; dlast = dvalid && e==last; busy = count!=0.
- Full with a same-cycle final-element pop and vin=1: both happen, count unchanged, no overflow.
- Empty with vin=1: count 0->1, nothing popped.
- Single-element case (rowsA=colsB=1): dfirst and dlast are asserted together, one transfer per matrix.
- State machine:
  - IDLE (count==0): dvalid=0; vin -> STREAM.
  - STREAM: emit elements; on final transfer, go to IDLE if count becomes 0, else stay in STREAM.
- Counters:
  - count is 0..depth, width $clog2(depth+1).
  - e has width $clog2(rowsA*colsB), compared against NELEM-1 (not wrap by overflow).
  - Pointers wrap explicitly at depth, so non-power-of-2 depth is legal.
- Reset mid-stream: immediate return to IDLE. All buffered data discarded; partial matrices are not resumed.
- No arithmetic on data; widths pass through unchanged.

Decomposition:
- Shared package matmult_pkg holds:
  - localparam functions for NELEM=rowsA*colsB, IDXW, PTRW, CNTW;
  - the state encoding (IDLE, STREAM);
  - the default dsize.
- One sub-module, matrix_slot_fifo: depth x (rowsA*colsB*dsize) storage with head/tail pointers, count, full/empty, push/pop, and same-cycle push+pop when full.
- Top level holds the FSM, element index, element mux, flags and overflow.

Test Plan (rowsA=colsB=2, dsize=8, depth=2 unless stated):
- Basic: C=0x04030201, one vin pulse, dready=1 -> dout 01,02,03,04 on consecutive cycles starting 1 cycle after capture; dfirst with 01, dlast with 04; busy falls after 04.
- Back-pressure: same C, dready toggled 1,0,0,1,0,1,1 -> each element held stable while dready=0; exactly 4 transfers in order; dvalid never drops mid-matrix.
- Back-to-back: vin two consecutive cycles with C=0x04030201 then 0x08070605, dready=1 -> 01..08 in 8 consecutive cycles, no bubble, dfirst at 01 and 05.
- Overflow: dready=0, three vin pulses with C=A1,B2,C3 patterns -> overflow=1 after third; later drain yields only matrices one and two.
- Full+pop: buffer full and vin=1 on the cycle of the final transfer (04) -> new matrix accepted, overflow stays 0, count stays 2.
- Reset mid-stream: rst=0 after 2 of 4 transfers -> dvalid=0, busy=0, overflow=0 asynchronously; a fresh vin afterwards streams from element 0.
